// File: rtl/cam_capture_fmt.sv
// Camera DVP capture front end (pclk domain).
// Skips a programmable number of start-up frames once the sensor is configured,
// packs byte pairs into pixels (RGB444, RGB565 or Y from YUYV), and issues one
// framebuffer write per pixel. Also reports frame completion, short/long lines,
// address overflow and a running count of captured frames.
module cam_capture_fmt #(
  parameter int MODE        = 0,    // 0: RGB444, 1: RGB565, 2: Y from YUYV
  parameter int PIX_W       = 12,
  parameter int H_ACT       = 640,
  parameter int V_ACT       = 480,
  parameter int ADDR_W      = 19,
  parameter int SKIP_FRAMES = 2
) (
  input  logic              pclk,
  input  logic              rst_n,
  input  logic              vsync,
  input  logic              href,
  input  logic [7:0]        D,
  input  logic              cam_done,
  output logic [ADDR_W-1:0] pix_addr,
  output logic [PIX_W-1:0]  pix_data,
  output logic              wr,
  output logic              frame_valid,
  output logic              line_err,
  output logic              ovf,
  output logic [7:0]        frame_cnt
);

  localparam logic [1:0] ST_WAIT = 2'd0;
  localparam logic [1:0] ST_IDLE = 2'd1;
  localparam logic [1:0] ST_CAPT = 2'd2;

  localparam logic [ADDR_W-1:0] MAX_ADDR = ADDR_W'(H_ACT * V_ACT - 1);
  localparam int                LC_W     = $clog2(H_ACT + 2);
  // Line counter stops at H_ACT+1 so an overlong line can never wrap back to H_ACT.
  localparam logic [LC_W-1:0]   LC_TGT   = LC_W'(H_ACT);
  localparam logic [LC_W-1:0]   LC_SAT   = LC_W'(H_ACT + 1);
  localparam logic [3:0]        SKIP_N   = 4'(SKIP_FRAMES);

  logic [1:0]        r_state;
  logic [3:0]        r_skip_cnt;
  logic              r_vs_s1;
  logic              r_vs_s2;
  logic              r_href_d;
  logic              r_phase;
  logic [7:0]        r_buf;
  logic [LC_W-1:0]   r_line_cnt;
  logic              r_full;
  logic [ADDR_W-1:0] r_pix_addr;
  logic [PIX_W-1:0]  r_pix_data;
  logic              r_wr;
  logic              r_frame_valid;
  logic              r_line_err;
  logic              r_ovf;
  logic [7:0]        r_frame_cnt;

  logic              w_frame_start;
  logic              w_frame_end;
  logic              w_href_fall;
  logic              w_capt_start;
  logic              w_capturing;
  logic              w_pix_evt;
  logic [PIX_W-1:0]  w_pix;

  // vsync falls at the start of a frame and rises at its end.
  assign w_frame_start = r_vs_s2 & ~r_vs_s1;
  assign w_frame_end   = ~r_vs_s2 & r_vs_s1;
  assign w_href_fall   = r_href_d & ~href;

  // Enter capture from WAIT once enough frames were skipped, or from IDLE on any frame.
  assign w_capt_start = cam_done & w_frame_start &
                        (((r_state == ST_WAIT) && (r_skip_cnt == SKIP_N)) ||
                         (r_state == ST_IDLE));
  // Bytes are ignored in the cycle the frame ends, even if href is still high.
  assign w_capturing  = cam_done & (r_state == ST_CAPT) & ~w_frame_end;
  assign w_pix_evt    = w_capturing & href & r_phase;

  // Pixel packing from the buffered first byte and the current second byte.
  generate
    if (MODE == 0) begin : g_rgb444
      logic [3:0] w_unused_hi;
      // Upper nibble of the first byte carries no RGB444 colour information.
      assign w_unused_hi = r_buf[7:4];
      assign w_pix       = PIX_W'({r_buf[3:0], D});
    end else if (MODE == 1) begin : g_rgb565
      assign w_pix = PIX_W'({r_buf, D});
    end else begin : g_yonly
      assign w_pix = PIX_W'(r_buf);
    end
  endgenerate

  // Two-flop vsync synchroniser and registered href for edge detection.
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      r_vs_s1  <= 1'b0;
      r_vs_s2  <= 1'b0;
      r_href_d <= 1'b0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
      r_vs_s1  <= vsync;
      r_vs_s2  <= r_vs_s1;
      r_href_d <= href;
    end
  end

  // Capture state machine and start-up frame skipping.
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_WAIT;
      r_skip_cnt <= 4'd0;
    end else if (!cam_done) begin
      r_state    <= ST_WAIT;
      r_skip_cnt <= 4'd0;
    end else begin
      case (r_state)
        ST_WAIT: begin
          if (w_capt_start)       r_state    <= ST_CAPT;
          else if (w_frame_start) r_skip_cnt <= r_skip_cnt + 4'd1;
        end
        ST_IDLE: begin
          if (w_capt_start) r_state <= ST_CAPT;
        end
        ST_CAPT: begin
          if (w_frame_end) r_state <= ST_IDLE;
        end
        default: r_state <= ST_WAIT;
      endcase
    end
  end

  // Byte pairing, pixel write, address guard and per-line length check.
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      r_phase    <= 1'b0;
      r_buf      <= 8'd0;
      r_line_cnt <= '0;
      r_full     <= 1'b0;
      r_pix_addr <= '0;
      r_pix_data <= '0;
      r_wr       <= 1'b0;
      r_line_err <= 1'b0;
      r_ovf      <= 1'b0;
    end else if (w_capt_start) begin
      r_phase    <= 1'b0;
      r_line_cnt <= '0;
      r_full     <= 1'b0;
      r_pix_addr <= '0;
      r_wr       <= 1'b0;
      r_line_err <= 1'b0;
      r_ovf      <= 1'b0;
    end else if (!w_capturing) begin
      r_phase <= 1'b0;
      r_wr    <= 1'b0;
    end else begin
      // Write only while the last framebuffer slot has not been used yet.
      r_wr <= w_pix_evt & ~r_full;
      if (w_pix_evt) begin
        if (r_full) r_ovf      <= 1'b1;
        else        r_pix_data <= w_pix;
      end
      // Address moves on in the cycle after each write; it parks on the last slot.
      if (r_wr) begin
        if (r_pix_addr == MAX_ADDR) r_full     <= 1'b1;
        else                        r_pix_addr <= r_pix_addr + ADDR_W'(1);
      end
      if (w_href_fall) begin
        // A dangling odd byte is simply forgotten by restarting the pair.
        r_phase    <= 1'b0;
        r_line_cnt <= '0;
        if (r_line_cnt != LC_TGT) r_line_err <= 1'b1;
      end else if (href) begin
        r_phase <= ~r_phase;
        if (!r_phase)                r_buf      <= D;
        else if (r_line_cnt != LC_SAT) r_line_cnt <= r_line_cnt + LC_W'(1);
      end
    end
  end

  // Frame completion pulse and captured-frame counter.
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      r_frame_valid <= 1'b0;
      r_frame_cnt   <= 8'd0;
    end else begin
      r_frame_valid <= cam_done & (r_state == ST_CAPT) & w_frame_end;
      if (cam_done && (r_state == ST_CAPT) && w_frame_end)
        r_frame_cnt <= r_frame_cnt + 8'd1;
    end
  end

  assign pix_addr    = r_pix_addr;
  assign pix_data    = r_pix_data;
  assign wr          = r_wr;
  assign frame_valid = r_frame_valid;
  assign line_err    = r_line_err;
  assign ovf         = r_ovf;
  assign frame_cnt   = r_frame_cnt;

endmodule
